// File: rtl/tensor_core_pkg.sv
// Shared types and constants for the tensor-core GEMM slice.
// FP16 field layout, Kulisch accumulator geometry and the tile FSM states.
package tensor_core_pkg;

  localparam int DWIDTH_D = 16;
  localparam int EWIDTH_D = 5;
  localparam int MWIDTH_D = 10;
  localparam int AWIDTH_D = 92;

  localparam int FP16_EXP_W = 5;
  localparam int FP16_MAN_W = 10;
  localparam int KUL_FRAC   = 48;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DRAIN
  } state_t;

  typedef struct packed {
    logic                  sign;
    logic [FP16_EXP_W-1:0] exp;
    logic [FP16_MAN_W-1:0] man;
  } fp16_t;

endpackage

// File: rtl/tensor_core_mma.sv
// One output cell: NUM-long FP16 dot product folded into a carry-save
// Kulisch pair (48 fraction bits). Inf/NaN operands contribute zero.
module tensor_core_mma
  import tensor_core_pkg::*;
#(
  parameter int NUM    = 4,
  parameter int DWIDTH = DWIDTH_D,
  parameter int EWIDTH = EWIDTH_D,
  parameter int MWIDTH = MWIDTH_D,
  parameter int AWIDTH = AWIDTH_D
) (
  input  logic [NUM*DWIDTH-1:0] a_vec,
  input  logic [NUM*DWIDTH-1:0] b_vec,
  input  logic [AWIDTH-1:0]     sum_in,
  input  logic [AWIDTH-1:0]     carry_in,
  output logic [AWIDTH-1:0]     sum_out,
  output logic [AWIDTH-1:0]     carry_out
);

  localparam int BIAS  = (1 << (EWIDTH - 1)) - 1;
  localparam int SHOFF = KUL_FRAC - 2 * BIAS - 2 * MWIDTH;
  localparam int SW    = 2 * (MWIDTH + 1);

  // Exact product of two FP16 values as a signed fixed-point term.
  // Subnormals use an effective exponent of 1 and no hidden bit.
  function automatic logic [AWIDTH-1:0] prod(
    input logic [DWIDTH-1:0] a,
    input logic [DWIDTH-1:0] b
  );
    logic [EWIDTH-1:0] ea;
    logic [EWIDTH-1:0] eb;
    logic [EWIDTH-1:0] fa;
    logic [EWIDTH-1:0] fb;
    logic [MWIDTH:0]   sa;
    logic [MWIDTH:0]   sb;
    logic [SW-1:0]     mag;
    logic [AWIDTH-1:0] t;
    int                sh;
    ea  = a[DWIDTH-2 -: EWIDTH];
    eb  = b[DWIDTH-2 -: EWIDTH];
    fa  = {ea[EWIDTH-1:1], ea[0] | ~|ea};
    fb  = {eb[EWIDTH-1:1], eb[0] | ~|eb};
    sa  = {|ea, a[MWIDTH-1:0]};
    sb  = {|eb, b[MWIDTH-1:0]};
    mag = SW'(sa) * SW'(sb);
    sh  = int'(fa) + int'(fb) + SHOFF;
    t   = AWIDTH'(mag);
    if (sh >= 0) t = t << sh;
    else t = t >> (-sh);
    if (&ea || &eb) t = '0;
    if (a[DWIDTH-1] ^ b[DWIDTH-1]) t = -t;
    return t;
  endfunction

  logic [AWIDTH-1:0] dot;
  logic [AWIDTH-1:0] maj;

  // Resolved dot product of this slice.
  always_comb begin
    dot = '0;
    for (int k = 0; k < NUM; k++) begin
      dot = dot + prod(a_vec[k*DWIDTH +: DWIDTH],
                       b_vec[k*DWIDTH +: DWIDTH]);
    end
  end

  // 3:2 compression keeps the accumulator in carry-save form.
  assign maj       = (sum_in & carry_in) |
                     (sum_in & dot) |
                     (carry_in & dot);
  assign sum_out   = sum_in ^ carry_in ^ dot;
  assign carry_out = maj << 1;

endmodule

// File: rtl/tensor_core_gemm_seq.sv
// Sequential MxN GEMM tile: C = A*B + C0 over k_beats slices of NUM.
// Define TC_GEMM_CPA_EN to resolve the carry-save pair at the output.
module tensor_core_gemm_seq
  import tensor_core_pkg::*;
#(
  parameter int M      = 4,
  parameter int N      = 4,
  parameter int NUM    = 4,
  parameter int DWIDTH = DWIDTH_D,
  parameter int EWIDTH = EWIDTH_D,
  parameter int MWIDTH = MWIDTH_D,
  parameter int AWIDTH = AWIDTH_D,
  parameter int KBW    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [KBW-1:0]          k_beats,
  input  logic                    c_load,
  input  logic [M*N*AWIDTH-1:0]   C_sum_in,
  input  logic [M*N*AWIDTH-1:0]   C_carry_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [M*NUM*DWIDTH-1:0] A_in,
  input  logic [NUM*N*DWIDTH-1:0] B_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [M*N*AWIDTH-1:0]   C_sum_out,
  output logic [M*N*AWIDTH-1:0]   C_carry_out,
  output logic                    busy
);

  localparam int TW = M * N * AWIDTH;
  localparam logic [KBW-1:0] ONE = KBW'(1);

  state_t         state;
  logic [KBW-1:0] kb_q;
  logic [KBW-1:0] cnt_q;
  logic [TW-1:0]  acc_sum;
  logic [TW-1:0]  acc_carry;
  logic [TW-1:0]  nxt_sum;
  logic [TW-1:0]  nxt_carry;
  logic           take;

  assign take = in_valid & in_ready;

  for (genvar r = 0; r < M; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      localparam int CI = r * N + c;
      logic [NUM*DWIDTH-1:0] b_col;

      for (genvar k = 0; k < NUM; k++) begin : g_k
        assign b_col[k*DWIDTH +: DWIDTH] =
          B_in[(k*N+c)*DWIDTH +: DWIDTH];
      end

      tensor_core_mma #(
        .NUM    (NUM),
        .DWIDTH (DWIDTH),
        .EWIDTH (EWIDTH),
        .MWIDTH (MWIDTH),
        .AWIDTH (AWIDTH)
      ) u_mma (
        .a_vec     (A_in[r*NUM*DWIDTH +: NUM*DWIDTH]),
        .b_vec     (b_col),
        .sum_in    (acc_sum[CI*AWIDTH +: AWIDTH]),
        .carry_in  (acc_carry[CI*AWIDTH +: AWIDTH]),
        .sum_out   (nxt_sum[CI*AWIDTH +: AWIDTH]),
        .carry_out (nxt_carry[CI*AWIDTH +: AWIDTH])
      );
    end
  end

  // Tile FSM, beat counter, accumulators and handshake flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      kb_q      <= '0;
      cnt_q     <= '0;
      acc_sum   <= '0;
      acc_carry <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            kb_q      <= k_beats;
            cnt_q     <= '0;
            acc_sum   <= c_load ? C_sum_in : '0;
            acc_carry <= c_load ? C_carry_in : '0;
            busy      <= 1'b1;
            if (k_beats != '0) begin
              state    <= ACC;
              in_ready <= 1'b1;
            end else begin
              state     <= DRAIN;
              out_valid <= 1'b1;
            end
          end
        end
        ACC: begin
          if (take) begin
            acc_sum   <= nxt_sum;
            acc_carry <= nxt_carry;
            cnt_q     <= cnt_q + ONE;
            if (cnt_q == kb_q - ONE) begin
              state     <= DRAIN;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef TC_GEMM_CPA_EN
  // Carry-propagate resolve straight off the accumulator registers.
  for (genvar i = 0; i < M * N; i++) begin : g_cpa
    assign C_sum_out[i*AWIDTH +: AWIDTH] =
      acc_sum[i*AWIDTH +: AWIDTH] +
      acc_carry[i*AWIDTH +: AWIDTH];
  end
  assign C_carry_out = '0;
`else
  // Raw carry-save pair for the downstream normaliser.
  assign C_sum_out   = acc_sum;
  assign C_carry_out = acc_carry;
`endif

endmodule

// File: tb/tb_tensor_core_gemm_seq.sv
// Directed bench for tensor_core_gemm_seq with a tile scoreboard.
// Expected tiles come from a real-valued FP16 reference model.
module tb_tensor_core_gemm_seq;

  localparam int M   = 4;
  localparam int N   = 4;
  localparam int NUM = 4;
  localparam int DW  = 16;
  localparam int EW  = 5;
  localparam int MW  = 10;
  localparam int AW  = 92;
  localparam int KBW = 8;
  localparam int TW  = M * N * AW;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [KBW-1:0]    k_beats = '0;
  logic              c_load = 1'b0;
  logic [TW-1:0]     C_sum_in = '0;
  logic [TW-1:0]     C_carry_in = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [M*NUM*DW-1:0] A_in = '0;
  logic [NUM*N*DW-1:0] B_in = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [TW-1:0]     C_sum_out;
  logic [TW-1:0]     C_carry_out;
  logic              busy;

  int n_asrt = 0;
  int n_fail = 0;

  logic [AW-1:0] mdl [M*N];
  logic [TW-1:0] sb_q [$];
  logic [15:0]   vtab [8] = '{16'h3C00, 16'h4000, 16'hBC00, 16'h3800,
                              16'h0000, 16'hC200, 16'h3555, 16'h0001};

  tensor_core_gemm_seq #(
    .M(M), .N(N), .NUM(NUM), .DWIDTH(DW), .EWIDTH(EW),
    .MWIDTH(MW), .AWIDTH(AW), .KBW(KBW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .k_beats     (k_beats),
    .c_load      (c_load),
    .C_sum_in    (C_sum_in),
    .C_carry_in  (C_carry_in),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .A_in        (A_in),
    .B_in        (B_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .C_sum_out   (C_sum_out),
    .C_carry_out (C_carry_out),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [AW-1:0] obs,
                     input logic [AW-1:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  function automatic real fp16_val(input logic [15:0] h);
    int  e;
    int  m;
    real v;
    e = int'(h[14:10]);
    m = int'(h[9:0]);
    if (e == 0) v = real'(m) * (2.0 ** (-24));
    else v = real'(1024 + m) * (2.0 ** (e - 25));
    return h[15] ? -v : v;
  endfunction

  function automatic logic [AW-1:0] to_fix(input real x);
    longint li;
    li = longint'(x * (2.0 ** 48));
    return {{(AW-64){li[63]}}, li};
  endfunction

  function automatic logic [AW-1:0] cell_tot(input int i);
    return C_sum_out[i*AW +: AW] + C_carry_out[i*AW +: AW];
  endfunction

  task automatic begin_tile(input int kb, input logic cl,
                            input logic [AW-1:0] seed);
    for (int i = 0; i < M * N; i++) begin
      C_sum_in[i*AW +: AW]   = seed - AW'(i * 3 + 1);
      C_carry_in[i*AW +: AW] = AW'(i * 3 + 1);
      mdl[i] = cl ? seed : '0;
    end
    k_beats = KBW'(kb);
    c_load  = cl;
    start   = 1'b1;
    tick();
    start      = 1'b0;
    c_load     = 1'b0;
    C_sum_in   = '0;
    C_carry_in = '0;
    chk1("busy_after_start", busy, 1'b1);
  endtask

  task automatic fill_rand();
    for (int i = 0; i < M * NUM; i++)
      A_in[i*DW +: DW] = vtab[$urandom_range(0, 7)];
    for (int i = 0; i < NUM * N; i++)
      B_in[i*DW +: DW] = vtab[$urandom_range(0, 7)];
  endtask

  task automatic model_beat();
    real d;
    for (int r = 0; r < M; r++) begin
      for (int c = 0; c < N; c++) begin
        d = 0.0;
        for (int k = 0; k < NUM; k++)
          d = d + fp16_val(A_in[(r*NUM+k)*DW +: DW]) *
                  fp16_val(B_in[(k*N+c)*DW +: DW]);
        mdl[r*N+c] = mdl[r*N+c] + to_fix(d);
      end
    end
  endtask

  task automatic send_beat(input int gap, input logic last,
                           input string tag);
    int w;
    in_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      tick();
      chk1({tag, "_gap_nout"}, out_valid, 1'b0);
      chk1({tag, "_gap_rdy"}, in_ready, 1'b1);
    end
    in_valid = 1'b1;
    model_beat();
    w = 0;
    while (!in_ready && w < 16) begin
      tick();
      w++;
    end
    chk1({tag, "_ready"}, in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    chk1({tag, "_oval_after"}, out_valid, last);
  endtask

  task automatic push_exp();
    logic [TW-1:0] t;
    for (int i = 0; i < M * N; i++) t[i*AW +: AW] = mdl[i];
    sb_q.push_back(t);
  endtask

  task automatic drain(input int hold, input string tag);
    int w;
    logic [TW-1:0] e;
    w = 0;
    while (!out_valid && w < 16) begin
      tick();
      w++;
    end
    chk1({tag, "_oval"}, out_valid, 1'b1);
    chk1({tag, "_sb_nonempty"}, sb_q.size() > 0, 1'b1);
    e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
    for (int h = 0; h <= hold; h++) begin
      for (int i = 0; i < M * N; i++)
        chk($sformatf("%s_h%0d_c%0d", tag, h, i), cell_tot(i),
            e[i*AW +: AW]);
      chk1({tag, "_hold_oval"}, out_valid, 1'b1);
      chk1({tag, "_hold_busy"}, busy, 1'b1);
      chk1({tag, "_hold_nrdy"}, in_ready, 1'b0);
      if (h < hold) begin
        start = (h == 1);
        tick();
        start = 1'b0;
      end
    end
    out_ready = 1'b1;
    start     = 1'b1;
    tick();
    out_ready = 1'b0;
    start     = 1'b0;
    chk1({tag, "_busy_fall"}, busy, 1'b0);
    chk1({tag, "_oval_fall"}, out_valid, 1'b0);
    tick();
    chk1({tag, "_start_ignored"}, busy, 1'b0);
  endtask

  initial begin
    logic [AW-1:0] one_fx;
    one_fx = AW'(1) << 48;

    #3;
    chk1("rst_in_ready", in_ready, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_sum_zero", |C_sum_out, 1'b0);
    chk1("rst_carry_zero", |C_carry_out, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    begin_tile(1, 1'b0, '0);
    A_in = '0;
    B_in = '0;
    for (int i = 0; i < NUM; i++) begin
      A_in[(i*NUM+i)*DW +: DW] = 16'h3C00;
      B_in[(i*N+i)*DW +: DW]   = 16'h3C00;
    end
    send_beat(0, 1'b1, "id");
    push_exp();
    chk("id_diag0", cell_tot(0), one_fx);
    chk("id_diag3", cell_tot(15), one_fx);
    chk("id_off", cell_tot(1), '0);
    drain(0, "id");

    begin_tile(3, 1'b0, '0);
    for (int i = 0; i < M * NUM; i++) A_in[i*DW +: DW] = 16'h3C00;
    for (int i = 0; i < NUM * N; i++) B_in[i*DW +: DW] = 16'h3C00;
    send_beat(2, 1'b0, "ones_b0");
    send_beat(0, 1'b0, "ones_b1");
    send_beat(3, 1'b1, "ones_b2");
    push_exp();
    chk("ones_c5", cell_tot(5), AW'(12) << 48);
    drain(0, "ones");

    begin_tile(0, 1'b1, AW'(5) << 48);
    chk1("seed_drain_now", out_valid, 1'b1);
    chk1("seed_nrdy", in_ready, 1'b0);
    push_exp();
    chk("seed_c7", cell_tot(7), AW'(5) << 48);
    drain(5, "seed");

    begin_tile(2, 1'b1, AW'(7) << 47);
    fill_rand();
    send_beat(1, 1'b0, "rnd_b0");
    fill_rand();
    send_beat(0, 1'b1, "rnd_b1");
    push_exp();
    drain(2, "rnd");

    begin_tile(4, 1'b0, '0);
    fill_rand();
    send_beat(0, 1'b0, "abort_b0");
    fill_rand();
    in_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk1("abort_nrdy", in_ready, 1'b0);
    chk1("abort_nbusy", busy, 1'b0);
    chk1("abort_noval", out_valid, 1'b0);
    chk1("abort_acc_zero", |C_sum_out, 1'b0);
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1("abort_quiet", out_valid, 1'b0);
    end

    begin_tile(3, 1'b1, -(AW'(3) << 48));
    fill_rand();
    send_beat(0, 1'b0, "post_b0");
    fill_rand();
    send_beat(1, 1'b0, "post_b1");
    fill_rand();
    send_beat(0, 1'b1, "post_b2");
    push_exp();
    drain(1, "post");

    chk1("sb_empty", sb_q.size() == 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/tensor_core_gemm_seq.md
Name: tensor_core_gemm_seq

Overview:
Sequential, parametrised M×N tensor-core GEMM engine computing C = A·B + C0 over a runtime-selectable K depth. K is streamed in slices of NUM per beat. The block holds an M×N carry-save Kulisch accumulator array internally and returns the finished tile through a valid/ready handshake. It sits between the operand fetch/stream buffers and the normalise/round stage that consumes carry-save Kulisch results.

Parameters:
M, 4, output tile rows
N, 4, output tile columns
NUM, 4, K elements consumed per beat (dot-product length)
DWIDTH, 16, FP16 operand width
EWIDTH, 5, FP16 exponent width
MWIDTH, 10, FP16 mantissa width
AWIDTH, 92, Kulisch accumulator width (1 sign + 11 k + 32 int + 48 frac)
KBW, 8, width of k_beats (maximum 2^KBW-1 beats per tile)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin tile; sampled only in IDLE
k_beats  in  KBW  number of K slices for this tile; sampled with start
c_load  in  1  1 = seed accumulators from C_*_in, 0 = seed zero; sampled with start
C_sum_in  in  M*N*AWIDTH  seed sum, packed [M-1:0][N-1:0][AWIDTH-1:0]
C_carry_in  in  M*N*AWIDTH  seed carry, same packing
in_valid  in  1  A/B slice valid
in_ready  out  1  block accepts slice
A_in  in  M*NUM*DWIDTH  A slice, [M-1:0][NUM-1:0][DWIDTH-1:0]
B_in  in  NUM*N*DWIDTH  B slice, row-major [NUM-1:0][N-1:0][DWIDTH-1:0]
out_valid  out  1  result tile valid
out_ready  in  1  consumer accepts tile
C_sum_out  out  M*N*AWIDTH  accumulator sum
C_carry_out  out  M*N*AWIDTH  accumulator carry
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE, beat counter=0, all accumulators=0. in_ready=0, out_valid=0, busy=0, C_*_out=0.
- FSM states: IDLE, ACC, DRAIN.
- IDLE, start=1: latch k_beats. Seed acc_sum/acc_carry from C_*_in if c_load=1, else from 0. Clear the counter.
  - k_beats≠0: go to ACC.
  - k_beats=0: go directly to DRAIN; the output is the seed.
- ACC: in_ready=1.
  - On in_valid&in_ready, every cell (r,c) updates acc ← mma(A_in[r][*], B_in[*][c], acc) in carry-save form. The MMA path is combinational and the result is registered, so one beat per cycle is sustained.
  - The counter increments per accepted beat.
  - When the accepted beat is beat k_beats-1, go to DRAIN next cycle.
  - in_valid=0 stalls with no update.
- DRAIN: in_ready=0, out_valid=1. C_*_out are driven from the registered accumulators and are stable while out_valid&!out_ready.
  - On out_ready: go to IDLE next cycle; accumulators are retained until the next start.
- start outside IDLE is ignored, including in the cycle of the output handshake; a new start is honoured only after busy falls.
- Latency: the first result is visible 1 cycle after the last accepted beat. Minimum tile time is k_beats+2 cycles (start, beats, drain).
- Arithmetic: the carry-save add wraps modulo 2^AWIDTH with no saturation. FP16 special values (inf/NaN) are handled exactly as the shared MMA cell defines them.
- Reset mid-operation aborts the tile immediately; no partial output is emitted.

Optional Feature:
TC_GEMM_CPA_EN
- Defined: in DRAIN, C_sum_out = acc_sum + acc_carry (AWIDTH bits, wrap) and C_carry_out = 0. The resolve is combinational from registers, so latency is unchanged.
- Undefined: raw carry-save pair is output.

Decomposition:
- Package tensor_core_pkg holds:
  - the state enum (IDLE/ACC/DRAIN);
  - default constants for DWIDTH/EWIDTH/MWIDTH/AWIDTH;
  - the FP16 field widths and the Kulisch fraction offset (48).
- Sub-module: an M×N generate array of the existing tensor_core_mma cell, one per output element. B columns are formed by index remapping.
- FSM, counter and accumulator registers live in the top.

Test Plan:
- Reset: rst_n=0 → in_ready=0, out_valid=0, busy=0, outputs 0.
- M=N=NUM=4, c_load=0, k_beats=1, A=B=identity (0x3C00 on diagonal):
  - out_valid exactly 1 cycle after the beat;
  - sum+carry = 2^48 on the diagonal, 0 off-diagonal.
- k_beats=3, all A,B elements 0x3C00 (1.0), random in_valid gaps:
  - each cell sum+carry = 12·2^48;
  - counter advances only on handshake.
- c_load=1, seed each cell 5·2^48, k_beats=0 → DRAIN next cycle, output equals seed.
- Backpressure: out_ready=0 for 5 cycles → outputs stable. A start pulse in DRAIN is ignored; busy falls 1 cycle after out_ready.
- rst_n pulsed low at beat 2 of 4 → immediate IDLE, no out_valid. A fresh tile afterwards gives correct results.
